dmem_ram_bridge: RTL and testbench

- Initiator for the data-side port of the dual-port core RAM.
- Accepts byte-addressed load/store requests from the core's memory stage over a valid/ready channel.
- Drives the RAM's word-addressed port B: address, read enable, write enable, byte strobes and write data.
- Returns aligned, sign- or zero-extended load data, or an error indication, over a valid/ready response channel.

---
 rtl/dmem_bridge_pkg.sv | 21 ++
 rtl/dmem_lane_fmt.sv | 49 ++++
 rtl/dmem_ram_bridge.sv | 126 ++++++++++++
 tb/tb_dmem_ram_bridge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory RAM bridge.
// Holds the access-size and FSM state encodings plus lane geometry.
package dmem_bridge_pkg;

   localparam int LANES     = 4;
   localparam int BYTE_BITS = 8;

   // Encoding 2'd3 is deliberately absent: it is the illegal size.
   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store strobes and data replication,
// load lane extraction with sign or zero extension.
module dmem_lane_fmt
   import dmem_bridge_pkg::*;
(
   input  logic [1:0]  st_off,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_web,
   output logic [31:0] st_wdata_rep,
   input  logic [1:0]  ld_off,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_q,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   always_comb begin
      st_web       = '0;
      st_wdata_rep = st_wdata;
      case (st_size)
         SZ_B: begin
            st_web       = 4'b0001 << st_off;
            st_wdata_rep = {LANES{st_wdata[BYTE_BITS-1:0]}};
         end
         SZ_H: begin
            st_web       = 4'b0011 << st_off;
            st_wdata_rep = {2{st_wdata[15:0]}};
         end
         SZ_W: st_web = 4'hF;
         default: st_web = '0;
      endcase
   end

   // Offset is in bytes, so the shift amount is offset * 8.
   assign ld_shift = ld_q >> {ld_off, 3'b000};

   always_comb begin
      ld_data = ld_shift;
      case (ld_size)
         SZ_B: ld_data = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
         SZ_H: ld_data = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/dmem_ram_bridge.sv
// Data-side initiator for RAM port B: byte-addressed load/store requests in,
// word-addressed RAM accesses out. Optional DMEM_BRIDGE_RANGE_CHECK_EN adds a depth check.
module dmem_ram_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int p_ADDR_BITS   = 32,
   parameter int p_DATA_BITS   = 32,
   parameter int p_MEM_ROW_NUM = 65536
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [p_ADDR_BITS-1:0] req_addr,
   input  logic                   req_wr,
   input  logic [1:0]             req_size,
   input  logic                   req_unsigned,
   input  logic [p_DATA_BITS-1:0] req_wdata,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [p_DATA_BITS-1:0] resp_rdata,
   output logic                   resp_err,
   output logic [p_ADDR_BITS-1:0] ram_addr,
   output logic                   ram_ren,
   output logic                   ram_wen,
   output logic [3:0]             ram_web,
   output logic [p_DATA_BITS-1:0] ram_wdata,
   input  logic [p_DATA_BITS-1:0] ram_q
);

`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
   localparam bit c_RANGE_CHECK = 1'b1;
`else
   localparam bit c_RANGE_CHECK = 1'b0;
`endif
   localparam logic [p_ADDR_BITS-1:0] c_ROWS = p_ADDR_BITS'(p_MEM_ROW_NUM);

   state_t                 state;
   logic [1:0]             ld_off;
   logic [1:0]             ld_size;
   logic                   ld_unsigned;
   logic [p_ADDR_BITS-1:0] word_idx;
   logic                   range_err;
   logic                   acc_err;
   logic                   accept;
   logic [3:0]             st_web;
   logic [31:0]            st_wdata_rep;
   logic [31:0]            ld_data;

   assign word_idx  = req_addr >> 2;
   assign range_err = c_RANGE_CHECK && (word_idx >= c_ROWS);
   assign acc_err   = (req_size == 2'd3)
                    | ((req_size == SZ_H) & req_addr[0])
                    | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                    | range_err;

   // RAM controls come straight from the request so the RAM samples them
   // on the same edge that accepts it.
   assign req_ready = (state == IDLE);
   assign accept    = req_ready & req_valid;
   assign ram_addr  = word_idx;
   assign ram_ren   = accept & ~acc_err & ~req_wr;
   assign ram_wen   = accept & ~acc_err & req_wr;
   assign ram_web   = ram_wen ? st_web : 4'b0000;
   assign ram_wdata = st_wdata_rep;

   dmem_lane_fmt u_lane_fmt (
      .st_off       (req_addr[1:0]),
      .st_size      (req_size),
      .st_wdata     (req_wdata),
      .st_web       (st_web),
      .st_wdata_rep (st_wdata_rep),
      .ld_off       (ld_off),
      .ld_size      (ld_size),
      .ld_unsigned  (ld_unsigned),
      .ld_q         (ram_q),
      .ld_data      (ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         ld_off      <= '0;
         ld_size     <= '0;
         ld_unsigned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (acc_err || req_wr) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= acc_err;
                     resp_rdata <= '0;
                  end else begin
                     state       <= READ;
                     ld_off      <= req_addr[1:0];
                     ld_size     <= req_size;
                     ld_unsigned <= req_unsigned;
                  end
               end
            end
            READ: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= ld_data;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ram_bridge.sv
// Bench for dmem_ram_bridge: behavioural byte-array reference model, a word RAM
// model on port B, directed scenarios followed by randomized transactions.
module tb_dmem_ram_bridge;

`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
   localparam int  ROWS     = 16;
   localparam bit  RANGE_ON = 1'b1;
`else
   localparam int  ROWS     = 65536;
   localparam bit  RANGE_ON = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_wr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] ram_addr;
   logic        ram_ren;
   logic        ram_wen;
   logic [3:0]  ram_web;
   logic [31:0] ram_wdata;
   logic [31:0] ram_q;

   int n_cmp;
   int n_mis;

   logic [31:0] ram     [0:255];
   logic [7:0]  ref_mem [0:1023];

   dmem_ram_bridge #(
      .p_ADDR_BITS   (32),
      .p_DATA_BITS   (32),
      .p_MEM_ROW_NUM (ROWS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wr       (req_wr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .ram_addr     (ram_addr),
      .ram_ren      (ram_ren),
      .ram_wen      (ram_wen),
      .ram_web      (ram_web),
      .ram_wdata    (ram_wdata),
      .ram_q        (ram_q)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM port B model: one-cycle read latency, byte-strobed writes
   always @(posedge clk) begin
      if (ram_wen) begin
         for (int k = 0; k < 4; k++) begin
            if (ram_web[k]) ram[ram_addr[7:0]][8*k +: 8] <= ram_wdata[8*k +: 8];
         end
      end
      if (ram_ren) ram_q <= ram[ram_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ren"}, 32'(ram_ren), 32'd0);
      chk({tag, "_wen"}, 32'(ram_wen), 32'd0);
      chk({tag, "_web"}, 32'(ram_web), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
   endtask

   // One complete transaction; called on a negedge with the bridge idle.
   task automatic xact(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold);
      int          n;
      int          lat;
      logic        err;
      logic [31:0] exp_d;
      logic [31:0] exp_web;
      logic [31:0] exp_wd;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
      err = 1'b0;
      if (n == 0) err = 1'b1;
      else if ((addr % n) != 0) err = 1'b1;
      if (RANGE_ON && ((addr / 4) >= ROWS)) err = 1'b1;

      exp_d   = '0;
      exp_web = '0;
      exp_wd  = '0;
      if (!err && !wr) begin
         for (int i = 0; i < n; i++) exp_d |= 32'(ref_mem[addr + i]) << (8 * i);
         if (!uns && n < 4 && exp_d[8*n-1]) exp_d |= 32'hFFFF_FFFF << (8 * n);
      end
      if (!err && wr) begin
         for (int i = 0; i < n; i++) exp_web |= 32'd1 << ((addr % 4) + i);
         for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wdata[8*(k % n) +: 8];
      end

      req_wr = wr; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1; resp_ready = 1'b0;
      #1;
      chk("acc_req_ready", 32'(req_ready), 32'd1);
      chk("acc_ram_ren", 32'(ram_ren), 32'(!err && !wr));
      chk("acc_ram_wen", 32'(ram_wen), 32'(!err && wr));
      chk("acc_ram_web", 32'(ram_web), exp_web);
      chk("acc_ram_addr", ram_addr, addr >> 2);
      if (!err && wr) chk("acc_ram_wdata", ram_wdata, exp_wd);
      @(posedge clk);
      if (!err && wr) begin
         for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end
      @(negedge clk);
      // a request held by the core while busy must be ignored
      req_valid = 1'($urandom_range(0, 1));
      req_wr = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 2));
      req_addr = 32'($urandom_range(0, 255) * 4);
      #1;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 8) begin
         chk_quiet("busy");
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), (err || wr) ? 32'd1 : 32'd2);
      chk("resp_rdata", resp_rdata, exp_d);
      chk("resp_err", 32'(resp_err), 32'(err));
      for (int h = 0; h < hold; h++) begin
         chk_quiet("hold");
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_rdata", resp_rdata, exp_d);
         chk("hold_err", 32'(resp_err), 32'(err));
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("post_valid", 32'(resp_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_size = '0;
      req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
      for (int w = 0; w < 256; w++) begin
         ram[w] = $urandom;
         for (int k = 0; k < 4; k++) ref_mem[4*w + k] = ram[w][8*k +: 8];
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_ren", 32'(ram_ren), 32'd0);
      chk("rst_wen", 32'(ram_wen), 32'd0);
      chk("rst_web", 32'(ram_web), 32'd0);
      @(negedge clk);

      // word store then word load at 0x100
      xact(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 0);
      xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);

      // reset while in READ discards the response
      req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h100; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      chk("midrst_rdata", resp_rdata, 32'd0);
      chk("midrst_err", 32'(resp_err), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // byte loads at the lane-3 boundary, signed and unsigned
      xact(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_7F01, 0);
      xact(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0);
      xact(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1);
      xact(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 0);

      // half store at upper half, misaligned and illegal accesses
      xact(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_A5A5, 0);
      xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
      xact(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0);
      xact(1'b1, 2'd1, 1'b0, 32'h105, 32'h1234_5678, 0);
      xact(1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 0);
      xact(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);

      // backpressure for 5 cycles
      xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5);
      xact(1'b1, 2'd0, 1'b0, 32'h3FF, 32'h0000_00C3, 5);

      // randomized traffic
      for (int t = 0; t < 150; t++) begin
         int          sel;
         int          nb;
         logic [1:0]  sz;
         logic [31:0] a;
         sel = $urandom_range(0, 9);
         sz  = (sel == 9) ? 2'd3 : 2'(sel % 3);
         nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         a   = 32'($urandom_range(0, 255) * 4);
         if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
         else a = a + 32'($urandom_range(0, (4 / nb) - 1) * nb);
         xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              $urandom, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
